// File: rtl/pacman_map_arbiter_if.sv
// Signal bundle between the two map-row requesters, the read arbiter and the
// map block memory read port.
interface pacman_map_arbiter_if;
    logic         req0;
    logic [5:0]   addr0;
    logic         gnt0;
    logic         rvalid0;
    logic [127:0] rdata0;

    logic         req1;
    logic [5:0]   addr1;
    logic         gnt1;
    logic         rvalid1;
    logic [127:0] rdata1;

    logic         mem_ena;
    logic [5:0]   mem_addra;
    logic [127:0] mem_douta;

    modport slave (
        input  req0, addr0, req1, addr1, mem_douta,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_ena, mem_addra
    );

    modport master (
        output req0, addr0, req1, addr1, mem_douta,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_ena, mem_addra
    );
endinterface

// File: rtl/pacman_map_arbiter.sv
// Two-port read arbiter for the Pacman map block memory: display port has
// priority, game-logic port gets a slot after MAX_WAIT consecutive denials.
module pacman_map_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 4
) (
    input logic                 clka,
    input logic                 rst,
    pacman_map_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic                req0, req1;
    logic                gnt0, gnt1;
    logic [3:0]          wcnt;
    logic [RD_LATENCY:0] vld_pipe;
    logic [RD_LATENCY:0] own_pipe;
    logic                ret_vld, ret_own;

    // Requests are masked by reset so grants drop the moment rst rises.
    assign req0 = bus.req0 & ~rst;
    assign req1 = bus.req1 & ~rst;

    assign gnt1     = req1 & (~req0 | (wcnt == WAIT_LIMIT));
    assign gnt0     = req0 & ~gnt1;
    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (~req1 | gnt1) begin
            wcnt <= '0;
        end else if (wcnt != WAIT_LIMIT) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            bus.mem_ena   <= 1'b0;
            bus.mem_addra <= '0;
        end else begin
            bus.mem_ena <= gnt0 | gnt1;
            if (gnt0) begin
                bus.mem_addra <= bus.addr0;
            end else if (gnt1) begin
                bus.mem_addra <= bus.addr1;
            end
        end
    end

    // Stage 0 lines up with mem_ena; stage RD_LATENCY lines up with mem_douta.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LATENCY-1:0], gnt0 | gnt1};
            own_pipe <= {own_pipe[RD_LATENCY-1:0], gnt1};
        end
    end

    assign ret_vld = vld_pipe[RD_LATENCY];
    assign ret_own = own_pipe[RD_LATENCY];

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
        end else begin
            bus.rvalid0 <= ret_vld & ~ret_own;
            bus.rvalid1 <= ret_vld & ret_own;
            if (ret_vld & ~ret_own) begin
                bus.rdata0 <= bus.mem_douta;
            end
            if (ret_vld & ret_own) begin
                bus.rdata1 <= bus.mem_douta;
            end
        end
    end
endmodule
